// File: rtl/j1_uart_if.sv
// J1 data-bus port of the UART: decoder select, word offset, strobes and data.
// The core drives the master side; the UART uses the slave side.
interface j1_uart_if;
  logic        sel;
  logic [1:0]  adr;
  logic        re;
  logic        we;
  logic [15:0] dat_i;
  logic [15:0] dat_o;

  modport master (output sel, adr, re, we, dat_i, input dat_o);
  modport slave  (input sel, adr, re, we, dat_i, output dat_o);
endinterface

// File: rtl/j1_uart.sv
// Memory-mapped 8N1 UART for the J1 data bus: TX/RX FIFOs, baud divisor, status.
// Define J1_UART_IRQ_EN to add the IE register at offset 3 and a live irq output.

module j1_uart_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic [7:0] wdata_i,
  output logic [7:0] rdata_o,
  output logic       empty_o,
  output logic       full_o
);
  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == DEPTH_C);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rp_q];

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop)      cnt_d = cnt_q + ONE_C;
    else if (do_pop && !do_push) cnt_d = cnt_q - ONE_C;
  end

  // NOTE: storage is not reset; only pointers and count need a known value.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= wdata_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + AW'(1);
      if (do_pop)  rp_q <= rp_q + AW'(1);
      cnt_q <= cnt_d;
    end
  end
endmodule

module j1_uart #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET  = 16'd433
) (
  input  logic     clk,
  input  logic     reset,
  j1_uart_if.slave bus,
  input  logic     rxd,
  output logic     txd,
  output logic     irq
);
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;

  logic wr, rd, wr_data, wr_div, rd_data, rd_stat;
  assign wr      = bus.sel & bus.we;
  assign rd      = bus.sel & bus.re;
  assign wr_data = wr & (bus.adr == 2'd0);
  assign wr_div  = wr & (bus.adr == 2'd2);
  assign rd_data = rd & (bus.adr == 2'd0);
  assign rd_stat = rd & (bus.adr == 2'd1);

  logic [15:0] div_q, div_eff, half_m1;
  assign div_eff = (div_q < 16'd3) ? 16'd3 : div_q;
  // First RX sample lands floor((div_eff+1)/2) clocks after the falling edge.
  assign half_m1 = (div_eff >> 1) - {15'd0, ~div_eff[0]};

  logic       tx_pop, tx_empty, tx_full, tx_idle;
  logic [7:0] tx_rdata;
  logic       rx_push, rx_empty, rx_full;
  logic [7:0] rx_rdata;

  uart_state_e tx_state_q, tx_state_d, rx_state_q, rx_state_d;
  logic [15:0] tx_tmr_q, tx_tmr_d, rx_tmr_q, rx_tmr_d;
  logic [2:0]  tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic [7:0]  tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
  logic        txd_q, txd_d;
  logic        rx_s1_q, rx_s2_q, rx_prev_q, rx_fall;
  logic        set_ovr, set_fe, ovr_q, ovr_d, fe_q, fe_d;
  logic [15:0] dat_q, dat_d, ie_rd;

  j1_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .reset(reset), .push_i(wr_data), .pop_i(tx_pop),
    .wdata_i(bus.dat_i[7:0]), .rdata_o(tx_rdata), .empty_o(tx_empty), .full_o(tx_full)
  );

  j1_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .reset(reset), .push_i(rx_push), .pop_i(rd_data),
    .wdata_i(rx_sh_q), .rdata_o(rx_rdata), .empty_o(rx_empty), .full_o(rx_full)
  );

  assign tx_idle = (tx_state_q == S_IDLE) & tx_empty;
  assign txd     = txd_q;
  assign rx_fall = rx_prev_q & ~rx_s2_q;

  // NOTE: every always_comb output gets its default first so no latch is inferred.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_tmr_d   = tx_tmr_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    txd_d      = txd_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      S_IDLE: if (!tx_empty) begin
        tx_pop = 1'b1; tx_sh_d = tx_rdata; tx_tmr_d = div_eff;
        tx_state_d = S_START; txd_d = 1'b0;
      end
      S_START: if (tx_tmr_q != '0) tx_tmr_d = tx_tmr_q - 16'd1;
      else begin
        tx_state_d = S_DATA; tx_bit_d = 3'd0; tx_tmr_d = div_eff; txd_d = tx_sh_q[0];
      end
      S_DATA: if (tx_tmr_q != '0) tx_tmr_d = tx_tmr_q - 16'd1;
      else begin
        tx_tmr_d = div_eff;
        if (tx_bit_q == 3'd7) begin
          tx_state_d = S_STOP; txd_d = 1'b1;
        end else begin
          tx_bit_d = tx_bit_q + 3'd1; tx_sh_d = {1'b0, tx_sh_q[7:1]}; txd_d = tx_sh_q[1];
        end
      end
      S_STOP: if (tx_tmr_q != '0) tx_tmr_d = tx_tmr_q - 16'd1;
      else if (!tx_empty) begin
        // Back-to-back: next start bit follows the stop bit with no idle gap.
        tx_pop = 1'b1; tx_sh_d = tx_rdata; tx_tmr_d = div_eff;
        tx_state_d = S_START; txd_d = 1'b0;
      end else tx_state_d = S_IDLE;
      default: tx_state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_tmr_d   = rx_tmr_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_push    = 1'b0;
    set_ovr    = 1'b0;
    set_fe     = 1'b0;
    case (rx_state_q)
      S_IDLE: if (rx_fall) begin
        rx_state_d = S_START; rx_tmr_d = half_m1;
      end
      S_START: if (rx_tmr_q != '0) rx_tmr_d = rx_tmr_q - 16'd1;
      else if (rx_s2_q) rx_state_d = S_IDLE;
      else begin
        rx_state_d = S_DATA; rx_bit_d = 3'd0; rx_tmr_d = div_eff;
      end
      S_DATA: if (rx_tmr_q != '0) rx_tmr_d = rx_tmr_q - 16'd1;
      else begin
        rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
        rx_tmr_d = div_eff;
        if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
        else rx_bit_d = rx_bit_q + 3'd1;
      end
      S_STOP: if (rx_tmr_q != '0) rx_tmr_d = rx_tmr_q - 16'd1;
      else begin
        rx_state_d = S_IDLE;
        if (!rx_s2_q)     set_fe  = 1'b1;
        else if (rx_full) set_ovr = 1'b1;
        else              rx_push = 1'b1;
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  // A set in the same cycle as a STATUS read wins over the read-clear.
  assign ovr_d = set_ovr | (ovr_q & ~rd_stat);
  assign fe_d  = set_fe  | (fe_q  & ~rd_stat);

  always_comb begin
    dat_d = dat_q;
    if (rd) begin
      case (bus.adr)
        2'd0:    dat_d = rx_empty ? 16'h0000 : {8'h00, rx_rdata};
        2'd1:    dat_d = {11'd0, fe_q, ovr_q, tx_idle, tx_full, ~rx_empty};
        2'd2:    dat_d = div_q;
        default: dat_d = ie_rd;
      endcase
    end
  end
  assign bus.dat_o = dat_q;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_q <= S_IDLE;  rx_state_q <= S_IDLE;
      tx_tmr_q   <= '0;      rx_tmr_q   <= '0;
      tx_bit_q   <= '0;      rx_bit_q   <= '0;
      tx_sh_q    <= '0;      rx_sh_q    <= '0;
      txd_q      <= 1'b1;
      rx_s1_q    <= 1'b1;    rx_s2_q    <= 1'b1;    rx_prev_q <= 1'b1;
      ovr_q      <= 1'b0;    fe_q       <= 1'b0;
      div_q      <= DIV_RESET;
      dat_q      <= '0;
    end else begin
      tx_state_q <= tx_state_d;  rx_state_q <= rx_state_d;
      tx_tmr_q   <= tx_tmr_d;    rx_tmr_q   <= rx_tmr_d;
      tx_bit_q   <= tx_bit_d;    rx_bit_q   <= rx_bit_d;
      tx_sh_q    <= tx_sh_d;     rx_sh_q    <= rx_sh_d;
      txd_q      <= txd_d;
      rx_s1_q    <= rxd;         rx_s2_q    <= rx_s1_q;  rx_prev_q <= rx_s2_q;
      ovr_q      <= ovr_d;       fe_q       <= fe_d;
      if (wr_div) div_q <= bus.dat_i;
      dat_q      <= dat_d;
    end
  end

`ifdef J1_UART_IRQ_EN
  logic [1:0] ie_q;
  logic       irq_q;
  logic       wr_ie;
  assign wr_ie = wr & (bus.adr == 2'd3);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ie_q  <= 2'b00;
      irq_q <= 1'b0;
    end else begin
      if (wr_ie) ie_q <= bus.dat_i[1:0];
      irq_q <= (ie_q[0] & ~rx_empty) | (ie_q[1] & tx_idle);
    end
  end
  assign ie_rd = {14'd0, ie_q};
  assign irq   = irq_q;
`else
  assign ie_rd = 16'd0;
  assign irq   = 1'b0;
`endif
endmodule
